// File: rtl/instruction_queue_if.sv
// Fetch-side, ROB-side and flush/commit signals of the instruction queue.
interface instruction_queue_if;
    logic        fetch_valid;
    logic [31:0] fetch_ins;
    logic [31:0] fetch_pc;
    logic        iq_full;
    logic        iq_empty;
    logic        rob_full;
    logic        if_ins_launch_flag;
    logic [31:0] if_ins;
    logic [31:0] if_ins_pc;
    logic        commit_flag;
    logic        commit_is_jalr;
    logic        rob_flush;
    logic        jalr_pending;

    // Environment side: fetcher and reorder buffer.
    modport master (
        output fetch_valid, fetch_ins, fetch_pc, rob_full,
               commit_flag, commit_is_jalr, rob_flush,
        input  iq_full, iq_empty, if_ins_launch_flag, if_ins, if_ins_pc, jalr_pending
    );

    // Queue side.
    modport slave (
        input  fetch_valid, fetch_ins, fetch_pc, rob_full,
               commit_flag, commit_is_jalr, rob_flush,
        output iq_full, iq_empty, if_ins_launch_flag, if_ins, if_ins_pc, jalr_pending
    );
endinterface

// File: rtl/instruction_queue.sv
// Instruction queue: FIFO between fetch and ROB issue, one launch per cycle,
// stalls after a JALR launch until that JALR commits, cleared by rob_flush.
module instruction_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    instruction_queue_if.slave   bus
);

    localparam int         CNT_W   = ADDR_W + 1;
    localparam logic [6:0] JALR_OP = 7'b1100111;

    typedef enum logic {
        RUN,
        JALR_WAIT
    } state_t;

    logic [31:0]       r_ins_mem [DEPTH];
    logic [31:0]       r_pc_mem  [DEPTH];
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [CNT_W-1:0]  r_count;
    state_t            r_state;
    logic              r_launch;
    logic [31:0]       r_ins;
    logic [31:0]       r_pc;
    logic              r_jalr_pending;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_head_ins;
    logic [31:0]       w_head_pc;
    logic              w_head_is_jalr;

    // Occupancy flags and push/pop qualification for this cycle.
    always_comb begin
        w_full         = (r_count == CNT_W'(DEPTH));
        w_empty        = (r_count == '0);
        w_push         = bus.fetch_valid && !w_full;
        w_pop          = (r_state == RUN) && !w_empty && !bus.rob_full;
        w_head_ins     = r_ins_mem[r_head];
        w_head_pc      = r_pc_mem[r_head];
        w_head_is_jalr = (w_head_ins[6:0] == JALR_OP);
    end

    assign bus.iq_full            = w_full;
    assign bus.iq_empty           = w_empty;
    assign bus.if_ins_launch_flag = r_launch;
    assign bus.if_ins             = r_ins;
    assign bus.if_ins_pc          = r_pc;
    assign bus.jalr_pending       = r_jalr_pending;

    // Entry storage; written at tail on an accepted push.
    always_ff @(posedge clk) begin
        if (rst && rdy && !bus.rob_flush && w_push) begin
            r_ins_mem[r_tail] <= bus.fetch_ins;
            r_pc_mem[r_tail]  <= bus.fetch_pc;
        end
    end

    // Pointers, count, launch registers and JALR-wait FSM; all frozen while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_state        <= RUN;
            r_launch       <= 1'b0;
            r_ins          <= '0;
            r_pc           <= '0;
            r_jalr_pending <= 1'b0;
        end else if (rdy) begin
            if (bus.rob_flush) begin
                r_head         <= '0;
                r_tail         <= '0;
                r_count        <= '0;
                r_state        <= RUN;
                r_launch       <= 1'b0;
                r_jalr_pending <= 1'b0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end

                if (w_pop) begin
                    r_head   <= r_head + 1'b1;
                    r_ins    <= w_head_ins;
                    r_pc     <= w_head_pc;
                    r_launch <= 1'b1;
                end else begin
                    r_launch <= 1'b0;
                end

                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase

                // jalr_pending tracks the next state so it rises with the JALR strobe.
                case (r_state)
                    RUN: begin
                        if (w_pop && w_head_is_jalr) begin
                            r_state        <= JALR_WAIT;
                            r_jalr_pending <= 1'b1;
                        end
                    end
                    JALR_WAIT: begin
                        if (bus.commit_flag && bus.commit_is_jalr) begin
                            r_state        <= RUN;
                            r_jalr_pending <= 1'b0;
                        end
                    end
                    default: begin
                        r_state        <= RUN;
                        r_jalr_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instruction_queue;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b0;

    instruction_queue_if bus ();

    instruction_queue #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a plain queue of {ins, pc} plus launch registers.
    logic [63:0] m_q[$];
    bit          m_wait = 1'b0;
    bit          m_flag = 1'b0;
    logic [31:0] m_ins  = '0;
    logic [31:0] m_pc   = '0;

    // Words the ROB accepts: strobe high at a clock edge with rdy high.
    logic [63:0] rob_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_wait = 1'b0;
            m_flag = 1'b0;
            m_ins  = '0;
            m_pc   = '0;
        end else if (rdy) begin
            if (bus.rob_flush) begin
                m_q.delete();
                m_wait = 1'b0;
                m_flag = 1'b0;
            end else begin
                int n;
                bit do_pop;
                logic [63:0] e;
                n      = m_q.size();
                do_pop = !m_wait && (n > 0) && !bus.rob_full;
                if (m_wait && bus.commit_flag && bus.commit_is_jalr) m_wait = 1'b0;
                if (do_pop) begin
                    e      = m_q.pop_front();
                    m_ins  = e[63:32];
                    m_pc   = e[31:0];
                    m_flag = 1'b1;
                    if (m_ins[6:0] == 7'h67) m_wait = 1'b1;
                end else begin
                    m_flag = 1'b0;
                end
                if (bus.fetch_valid && n < 8) m_q.push_back({bus.fetch_ins, bus.fetch_pc});
            end
        end
    end

    always @(posedge clk) begin
        if (rst && rdy && bus.if_ins_launch_flag)
            rob_log.push_back({bus.if_ins, bus.if_ins_pc});
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("flag",    32'(bus.if_ins_launch_flag), 32'(m_flag));
        chk("ins",     bus.if_ins,                  m_ins);
        chk("pc",      bus.if_ins_pc,               m_pc);
        chk("pending", 32'(bus.jalr_pending),       32'(m_wait));
        chk("full",    32'(bus.iq_full),            32'(m_q.size() == 8));
        chk("empty",   32'(bus.iq_empty),           32'(m_q.size() == 0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.fetch_valid    = 1'b0;
        bus.commit_flag    = 1'b0;
        bus.commit_is_jalr = 1'b0;
        bus.rob_flush      = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
        bus.fetch_valid = 1'b1;
        bus.fetch_ins   = ins;
        bus.fetch_pc    = pc;
    endtask

    initial begin
        idle();
        bus.fetch_ins = '0;
        bus.fetch_pc  = '0;
        bus.rob_full  = 1'b0;
        rdy = 1'b1;
        step(); step();
        rst = 1'b1;
        step();

        // 1. async reset mid-traffic, then first launch latency
        for (int i = 0; i < 3; i++) begin
            fetch(32'h00000033, 32'(i * 4));
            step();
        end
        chk("t1_flag_before_rst", 32'(bus.if_ins_launch_flag), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t1_rst_flag",  32'(bus.if_ins_launch_flag), 32'd0);
        chk("t1_rst_ins",   bus.if_ins,    32'h0);
        chk("t1_rst_pc",    bus.if_ins_pc, 32'h0);
        chk("t1_rst_empty", 32'(bus.iq_empty), 32'd1);
        idle();
        step();
        rst = 1'b1;
        step();
        fetch(32'h00500093, 32'h0);
        step();
        idle();
        chk("t1_no_bypass", 32'(bus.if_ins_launch_flag), 32'd0);
        step();
        chk("t1_flag", 32'(bus.if_ins_launch_flag), 32'd1);
        chk("t1_ins",  bus.if_ins,    32'h00500093);
        chk("t1_pc",   bus.if_ins_pc, 32'h0);
        step();

        // 2. fill to 8, 9th dropped, drain in order
        rob_log.delete();
        bus.rob_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            fetch(32'h00000013 | 32'(i << 7), 32'(i * 4));
            step();
        end
        idle();
        chk("t2_full", 32'(bus.iq_full), 32'd1);
        bus.rob_full = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("t2_empty", 32'(bus.iq_empty), 32'd1);
        chk("t2_count", 32'(rob_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < rob_log.size(); i++)
            chk("t2_order_pc", rob_log[i][31:0], 32'(i * 4));

        // 3. JALR stall until commit
        fetch(32'h000080E7, 32'h100);
        step();
        fetch(32'h00100093, 32'h104);
        step();
        idle();
        chk("t3_jalr_flag", 32'(bus.if_ins_launch_flag), 32'd1);
        chk("t3_jalr_ins",  bus.if_ins, 32'h000080E7);
        chk("t3_pending",   32'(bus.jalr_pending), 32'd1);
        step(); step(); step();
        chk("t3_held_flag",  32'(bus.if_ins_launch_flag), 32'd0);
        chk("t3_held_empty", 32'(bus.iq_empty), 32'd0);
        bus.commit_flag    = 1'b1;
        bus.commit_is_jalr = 1'b1;
        step();
        idle();
        chk("t3_commit_noflag", 32'(bus.if_ins_launch_flag), 32'd0);
        chk("t3_commit_pend",   32'(bus.jalr_pending), 32'd0);
        step();
        chk("t3_addi_flag", 32'(bus.if_ins_launch_flag), 32'd1);
        chk("t3_addi_ins",  bus.if_ins,    32'h00100093);
        chk("t3_addi_pc",   bus.if_ins_pc, 32'h104);
        step();

        // 4. flush with 5 queued and a same-cycle fetch
        bus.rob_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch(32'h00000013, 32'h200 + 32'(i * 4));
            step();
        end
        bus.rob_flush = 1'b1;
        fetch(32'h00700093, 32'h300);
        step();
        idle();
        bus.rob_full = 1'b0;
        chk("t4_empty", 32'(bus.iq_empty), 32'd1);
        step();
        chk("t4_noflag", 32'(bus.if_ins_launch_flag), 32'd0);
        chk("t4_lost",   32'(bus.iq_empty), 32'd1);
        fetch(32'h000080E7, 32'h400);
        step();
        idle();
        step();
        chk("t4_wait_pend", 32'(bus.jalr_pending), 32'd1);
        fetch(32'h00000013, 32'h404);
        step();
        fetch(32'h00000013, 32'h408);
        step();
        bus.rob_flush = 1'b1;
        fetch(32'h00000013, 32'h40C);
        step();
        idle();
        chk("t4_flush_pend",  32'(bus.jalr_pending), 32'd0);
        chk("t4_flush_empty", 32'(bus.iq_empty), 32'd1);
        step();

        // 5. rdy low freezes a pending strobe
        rob_log.delete();
        fetch(32'h00A00093, 32'h500);
        step();
        fetch(32'h00B00093, 32'h504);
        step();
        idle();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_frz_flag",  32'(bus.if_ins_launch_flag), 32'd1);
            chk("t5_frz_ins",   bus.if_ins, 32'h00A00093);
            chk("t5_frz_empty", 32'(bus.iq_empty), 32'd0);
        end
        rdy = 1'b1;
        step(); step(); step();
        chk("t5_accepts", 32'(rob_log.size()), 32'd2);
        if (rob_log.size() >= 2) begin
            chk("t5_first",  rob_log[0][63:32], 32'h00A00093);
            chk("t5_second", rob_log[1][63:32], 32'h00B00093);
        end

        // 6. wrap-around at full rate
        rob_log.delete();
        for (int i = 0; i < 20; i++) begin
            fetch(32'h00000013 | 32'((i & 31) << 15), 32'h600 + 32'(i * 4));
            step();
            if (i > 0) chk("t6_empty", 32'(bus.iq_empty), 32'd0);
        end
        idle();
        step(); step(); step();
        chk("t6_count", 32'(rob_log.size()), 32'd20);
        for (int i = 0; i < 20 && i < rob_log.size(); i++)
            chk("t6_order_pc", rob_log[i][31:0], 32'h600 + 32'(i * 4));
        chk("t6_drained", 32'(bus.iq_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
